// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift/rotate engine: op codes, FSM states
// and the pass-through decode helper.
package shift_pkg;

  typedef enum logic [2:0] {
    OP_SHR  = 3'd0,
    OP_SHRA = 3'd1,
    OP_SHL  = 3'd2,
    OP_ROR  = 3'd3,
    OP_ROL  = 3'd4
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } shift_state_e;

  // Codes 101..111 return the operand unchanged.
  function automatic logic is_passthru(input logic [2:0] op);
    return op > 3'd4;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational shift/rotate of a WIDTH vector by 0..STEP bits under one op.
// With SHIFT_CARRY_EN defined it also reports the last bit shifted out.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SH_W  = 3
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       op,
  input  logic [SH_W-1:0]  sh,
  input  logic             sign_fill,
`ifdef SHIFT_CARRY_EN
  output logic             carry,
`endif
  output logic [WIDTH-1:0] shifted
);

  localparam logic [WIDTH-1:0] ONES = '1;

  logic [WIDTH-1:0] shr_v, shl_v, ror_v, rol_v, fill_v;

  // Shifting by WIDTH yields zero, so sh=0 leaves rotates unchanged.
  assign shr_v  = data >> sh;
  assign shl_v  = data << sh;
  assign ror_v  = shr_v | (data << (WIDTH - int'(sh)));
  assign rol_v  = shl_v | (data >> (WIDTH - int'(sh)));
  assign fill_v = sign_fill ? ~(ONES >> sh) : '0;

  always_comb begin
    shifted = data;
    case (op)
      OP_SHR:  shifted = shr_v;
      OP_SHRA: shifted = shr_v | fill_v;
      OP_SHL:  shifted = shl_v;
      OP_ROR:  shifted = ror_v;
      OP_ROL:  shifted = rol_v;
      default: shifted = data;
    endcase
  end

`ifdef SHIFT_CARRY_EN
  localparam int IDX_W = $clog2(WIDTH);

  logic [IDX_W-1:0] idx_r, idx_l;

  always_comb begin
    idx_r = IDX_W'(sh - SH_W'(1));
    idx_l = IDX_W'(WIDTH - int'(sh));
    carry = 1'b0;
    if (sh != '0) begin
      case (op)
        OP_SHR, OP_SHRA: carry = data[idx_r];
        OP_SHL:          carry = data[idx_l];
        OP_ROR:          carry = ror_v[WIDTH-1];
        OP_ROL:          carry = rol_v[0];
        default:         carry = 1'b0;
      endcase
    end
  end
`endif

endmodule

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate engine, STEP bits per clock, start/busy/done handshake.
// Optional carry_out port is enabled by defining SHIFT_CARRY_EN.
module shift_rotate_unit
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 4,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             Clear_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
`ifdef SHIFT_CARRY_EN
  output logic             carry_out,
`endif
  output logic [1:0]       state_dbg
);

  // Handshake: start is sampled only in IDLE; the edge that samples it (E0)
  // captures op/operand/amt, after which they are don't-care. busy covers
  // SHIFT and DONE, done pulses for one cycle with result final and held until
  // the next accepted start. A start seen while busy is dropped, not queued.

  localparam int               SH_W   = $clog2(STEP + 1);
  localparam logic [AMT_W:0]   STEP_X = (AMT_W + 1)'(STEP);

  shift_state_e     state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_next;
  logic [2:0]       op_q;
  logic             sign_q;
  logic [AMT_W:0]   rem_x, s_x;
  logic [SH_W-1:0]  sh;
  logic [WIDTH-1:0] step_out;
  logic             accept, go_shift;

  assign accept   = (state_q == ST_IDLE) && start;
  assign go_shift = (amt != '0) && !is_passthru(op);

  always_comb begin
    rem_x    = {1'b0, rem_q};
    s_x      = (rem_x < STEP_X) ? rem_x : STEP_X;
    sh       = SH_W'(s_x);
    rem_next = AMT_W'(rem_x - s_x);
  end

`ifdef SHIFT_CARRY_EN
  logic step_carry;
`endif

  shift_step #(
    .WIDTH (WIDTH),
    .SH_W  (SH_W)
  ) u_step (
    .data      (result),
    .op        (op_q),
    .sh        (sh),
    .sign_fill (sign_q),
`ifdef SHIFT_CARRY_EN
    .carry     (step_carry),
`endif
    .shifted   (step_out)
  );

  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = go_shift ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (rem_next == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n) begin
      result <= '0;
      rem_q  <= '0;
      op_q   <= '0;
      sign_q <= 1'b0;
    end else if (accept) begin
      result <= operand;
      rem_q  <= go_shift ? amt : '0;
      op_q   <= op;
      sign_q <= operand[WIDTH-1];
    end else if (state_q == ST_SHIFT) begin
      result <= step_out;
      rem_q  <= rem_next;
    end
  end

`ifdef SHIFT_CARRY_EN
  // Each step records its own last bit out; the final step leaves the overall one.
  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n)                   carry_out <= 1'b0;
    else if (accept)                carry_out <= 1'b0;
    else if (state_q == ST_SHIFT)   carry_out <= step_carry;
  end
`endif

  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed-vector bench for shift_rotate_unit: driver pushes expected results,
// a negedge monitor pops and compares whenever done is high.
module tb_shift_rotate_unit;
  localparam int WIDTH = 32;
  localparam int AMT_W = 5;

  logic             clk = 1'b0;
  logic             clear_n = 1'b0;
  logic             start = 1'b0;
  logic [2:0]       op = '0;
  logic [WIDTH-1:0] operand = '0;
  logic [AMT_W-1:0] amt = '0;
  logic [WIDTH-1:0] result;
  logic             busy, done;
  logic [1:0]       state_dbg;
`ifdef SHIFT_CARRY_EN
  logic             carry_out;
`endif

  shift_rotate_unit #(.WIDTH(32), .STEP(4)) dut (
    .clk       (clk),
    .Clear_n   (clear_n),
    .start     (start),
    .op        (op),
    .operand   (operand),
    .amt       (amt),
    .result    (result),
    .busy      (busy),
    .done      (done),
`ifdef SHIFT_CARRY_EN
    .carry_out (carry_out),
`endif
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [WIDTH-1:0] exp_q[$];
  int               exp_cyc_q[$];
  int               exp_busy_q[$];
  logic             exp_c_q[$];
  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;

  typedef struct {
    logic [2:0]       o;
    logic [WIDTH-1:0] d;
    logic [AMT_W-1:0] a;
    logic [WIDTH-1:0] r;
    logic             c;
  } vec_t;
  vec_t vecs[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int steps_for(input logic [2:0] o, input logic [AMT_W-1:0] a);
    if (o > 3'd4 || a == '0) return 0;
    return (int'(a) + 3) / 4;
  endfunction

  function automatic void push_exp(input logic [2:0] o, input logic [AMT_W-1:0] a,
                                   input logic [WIDTH-1:0] r, input logic c);
    int k;
    k = steps_for(o, a);
    exp_q.push_back(r);
    exp_cyc_q.push_back(cyc + 1 + k);
    exp_busy_q.push_back(k + 1);
    exp_c_q.push_back(c);
  endfunction

  // monitor
  always @(negedge clk) begin
    if (!clear_n) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: result %h with empty queue (t=%0t)", result, $time);
        end else begin
          check("result", result, exp_q.pop_front());
          check("latency_cycle", cyc, exp_cyc_q.pop_front());
          check("busy_cycles", busy_cnt, exp_busy_q.pop_front());
`ifdef SHIFT_CARRY_EN
          check("carry_out", {31'b0, carry_out}, {31'b0, exp_c_q.pop_front()});
`else
          void'(exp_c_q.pop_front());
`endif
        end
        busy_cnt = 0;
      end
    end
  end

  // driver tasks
  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete(); exp_cyc_q.delete(); exp_busy_q.delete(); exp_c_q.delete();
    @(negedge clk);
  endtask

  task automatic issue(input vec_t v);
    @(negedge clk);
    op = v.o; operand = v.d; amt = v.a; start = 1'b1;
    push_exp(v.o, v.a, v.r, v.c);
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom_range(0, 7));
    operand = $urandom;
    amt = AMT_W'($urandom_range(0, 31));
    wait_drain();
  endtask

  initial begin
    vecs.push_back('{3'd3, 32'h0000001E, 5'd7,  32'h3C000000, 1'b0});
    vecs.push_back('{3'd1, 32'h80000000, 5'd31, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{3'd0, 32'h80000000, 5'd31, 32'h00000001, 1'b0});
    vecs.push_back('{3'd2, 32'h00000005, 5'd0,  32'h00000005, 1'b0});
    vecs.push_back('{3'd4, 32'h80000001, 5'd1,  32'h00000003, 1'b1});
    vecs.push_back('{3'd0, 32'h00000003, 5'd1,  32'h00000001, 1'b1});
    vecs.push_back('{3'd2, 32'h80000000, 5'd1,  32'h00000000, 1'b1});
    vecs.push_back('{3'd6, 32'hDEADBEEF, 5'd5,  32'hDEADBEEF, 1'b0});
    vecs.push_back('{3'd4, 32'h12345678, 5'd8,  32'h34567812, 1'b0});
    vecs.push_back('{3'd1, 32'hF000000F, 5'd4,  32'hFF000000, 1'b1});
    vecs.push_back('{3'd2, 32'h00000001, 5'd31, 32'h80000000, 1'b0});
    vecs.push_back('{3'd3, 32'h00000001, 5'd5,  32'h08000000, 1'b0});

    #1;
    check("reset_result", result, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_state", {30'b0, state_dbg}, 32'h0);
`ifdef SHIFT_CARRY_EN
    check("reset_carry", {31'b0, carry_out}, 32'h0);
`endif
    @(negedge clk);
    @(negedge clk);
    clear_n = 1'b1;

    foreach (vecs[i]) issue(vecs[i]);

    // Extra starts during SHIFT and DONE must be dropped.
    @(negedge clk);
    op = 3'd3; operand = 32'h1E; amt = 5'd7; start = 1'b1;
    push_exp(3'd3, 5'd7, 32'h3C000000, 1'b0);
    repeat (3) begin
      @(negedge clk);
      start = 1'b1;
      op = 3'd0;
      operand = $urandom;
      amt = AMT_W'($urandom_range(1, 31));
    end
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (10) @(negedge clk);
    check("ignored_start_result_held", result, 32'h3C000000);

    // Asynchronous reset in the middle of a long shift.
    @(negedge clk);
    op = 3'd0; operand = 32'hFFFFFFFF; amt = 5'd31; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 clear_n = 1'b0;
    #1;
    check("abort_result", result, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    check("abort_state", {30'b0, state_dbg}, 32'h0);
    @(negedge clk);
    #2 clear_n = 1'b1;
    issue('{3'd0, 32'h00000010, 5'd4, 32'h00000001, 1'b0});

    repeat (5) @(negedge clk);
    check("queue_empty_at_end", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_rotate_unit.md
Name: shift_rotate_unit

Overview:
- Parametrised multi-cycle shift/rotate engine for the datapath ALU; next generation of the fixed single-cycle ROR path.
- Supports logical/arithmetic shifts and both rotate directions at any WIDTH, shifting STEP bits per clock.
- Has a start/busy/done handshake so the control unit can sequence it like the Y→ALU→Z path.
- Operand comes from Y, amount from bus low bits; result feeds Z-low.

Parameters:
- WIDTH, 32, data width in bits (power of 2, ≥8).
- STEP, 4, maximum bits shifted per clock (power of 2, 1..WIDTH).
- AMT_W, $clog2(WIDTH), derived localparam; width of the shift amount.

Ports:
- clk  in  1  system clock, rising edge.
- Clear_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL; 101–111 pass-through.
- operand  in  WIDTH  value to shift (Y register).
- amt  in  AMT_W  shift count, 0..WIDTH-1.
- result  out  WIDTH  shifted value; valid when done=1; held until the next accepted start.
- busy  out  1  high in SHIFT and DONE.
- done  out  1  one-cycle pulse when result is final.

Behaviour:
- Reset (Clear_n=0, async): state=IDLE; result=0, busy=0, done=0; internal remaining count=0. Reset mid-operation aborts immediately, with no partial completion.
- FSM states: IDLE, SHIFT, DONE.
- IDLE→SHIFT: at the edge E0 with start=1 and amt≠0 and op not pass-through. At E0, latch op, load result←operand and rem←amt.
- IDLE→DONE: at E0 when amt=0 or op is pass-through. Load result←operand.
- SHIFT: each edge applies s=min(rem,STEP) bits of the latched op to result, then rem←rem−s. When rem reaches 0, go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- Latency: done is high in the cycle after edge E0+k, where k=ceil(amt/STEP). For amt=0, k=0.
- Shift fill rules:
  - SHR fills zeros.
  - SHRA replicates the latched operand MSB on every step.
  - SHL fills zeros.
  - ROR/ROL wrap bits; rotate by amt equals single-cycle rotate by amt.
- Handshake: start is ignored while busy=1, including the DONE cycle; the requester must reassert. op, operand and amt are don't-care after E0.
- Intermediate result values during SHIFT are visible but not valid.

Optional Feature:
- Macro SHIFT_CARRY_EN adds output port carry_out (1 bit), reset 0, valid with done and held with result.
- carry_out is the last bit shifted out:
  - SHR/SHRA: operand[amt-1].
  - SHL: operand[WIDTH-amt].
  - ROR: result[WIDTH-1].
  - ROL: result[0].
  - amt=0 or pass-through: 0.
- Without the macro the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package shift_pkg holds:
  - Op encodings (OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL).
  - FSM state encoding (ST_IDLE, ST_SHIFT, ST_DONE).
- Sub-module shift_step: combinational shift of a WIDTH vector by 0..STEP under a given op, plus a sign-fill input. It is instantiated once in the datapath register loop.

Test Plan:
- ROR, operand=30 (0x1E), amt=7, STEP=4 → done after E0+2; result=0x3C000000; busy high for 2+1 cycles.
- SHRA, operand=0x80000000, amt=31 → done after E0+8; result=0xFFFFFFFF. Also SHR on the same operand → 0x00000001.
- SHL, operand=5, amt=0 → done in the cycle after E0; result=5. Also ROL, 0x80000001, amt=1 → 0x00000003.
- start pulsed at E0 with ROR amt=7, then pulsed again with different operand during SHIFT and during DONE → both ignored; result=0x3C000000; only one done pulse.
- Clear_n driven low mid-SHIFT → result=0, busy=0, done=0 immediately. After release, a new start (SHR 0x10 by 4) → result=0x1.
- With SHIFT_CARRY_EN: SHR 0x3 by 1 → result=0x1, carry_out=1; SHL 0x80000000 by 1 → result=0, carry_out=1; amt=0 → carry_out=0.
